ram_timing_ctrl: RTL and testbench
==================================

RAM_TIMING_CTRL -- requirements
Module: ram_timing_ctrl

Interface
REQ-001 Parameter LAT, default 2, sets the number of BUSY cycles before ACCESS (0 is legal).
REQ-002 Parameter DEPTH, default 16384, sets the number of 32-bit words in the array.
REQ-003 Port CLK  in  1  system clock; all state updates on its rising edge.
REQ-004 Port RST  in  1  reset, synchronous, active-high.
REQ-005 Port ramREN  in  1  read request from memory_control.
REQ-006 Port ramWEN  in  1  write request from memory_control.
REQ-007 Port ramaddr  in  32  byte address (word_t); bits [1:0] are ignored.
REQ-008 Port ramstore  in  32  write data (word_t).
REQ-009 Port ramload  out  32  read data (word_t).
REQ-010 Port ramstate  out  ramstate_t  FREE / BUSY / ACCESS / ERROR, from cpu_types_pkg.

Function
REQ-011 Internal FSM states: IDLE, WAIT, ACC and ERR, driving ramstate FREE, BUSY, ACCESS and ERROR respectively.
REQ-012 ramstate shall be a function of the registered FSM state only, never of current inputs.
REQ-013 Word index is ramaddr[31:2]; an index >= DEPTH is "out of range".
REQ-014 Request terms:
- "valid": exactly one of ramREN/ramWEN is high and the index is in range.
- "bad": both are high, or either is high with an out-of-range index.
- "none": both are low.
REQ-015 Transitions from IDLE:
- none -> IDLE.
- bad -> ERR.
- valid -> WAIT (LAT>0) or ACC (LAT=0).
REQ-016 On each entry to WAIT, the block captures REN, WEN, the index and ramstore into a request latch, and a cycle counter loads 1.
REQ-017 Transitions from WAIT:
- none -> IDLE.
- bad -> ERR.
- inputs differ from the latch -> WAIT with latch recaptured and counter reloaded to 1 (restart).
- inputs equal the latch and counter==LAT -> ACC.
- otherwise -> WAIT with counter incremented.
REQ-018 When LAT=0, the request latch shall be captured on the transition into ACC.
REQ-019 In ACC, the operation uses only latched values; input changes during ACC have no effect on that operation.
REQ-020 ACC read: ramload = array[latched index], combinationally, during the ACC cycle.
REQ-021 ACC write: array[latched index] <= latched store at the clock edge ending ACC; ramload = 0.
REQ-022 Transitions out of ACC are evaluated as from IDLE (REQ-015); a still-held request is a new transaction.
REQ-023 Transitions from ERR: bad -> ERR; none -> IDLE; valid -> WAIT/ACC per REQ-015 with a fresh latch.
REQ-024 ramload shall be 0 in every state other than ACC-read.
REQ-025 No write shall occur in IDLE, WAIT or ERR.
REQ-026 Latency: a valid request first seen in IDLE at cycle n gives ACCESS at cycle n+LAT+1, provided there is no restart.
REQ-027 Counter width shall be $clog2(LAT+1)+1 bits and shall never wrap.

Reset
REQ-028 With RST high at a rising edge, the next state shall be IDLE, the counter 0 and the latch cleared.
REQ-029 During reset, ramstate = FREE and ramload = 0.
REQ-030 RST shall take priority over every transition, including ACC; an asserted RST in an ACC-write cycle shall suppress the write.
REQ-031 Array contents shall not be cleared by RST; they are zero at time 0 and may be preloaded by the bench.

Verification (LAT=2 unless stated)
REQ-032 Preload word 0x100=0xDEADBEEF; ramREN, addr 0x100 from c0 -> FREE c0, BUSY c1-c2, ACCESS c3 with ramload=0xDEADBEEF; REN dropped c4 -> FREE c5.
REQ-033 ramWEN addr 0x40, data 0x12345678 -> ACCESS c3, ramload=0; then read of 0x40 -> ramload=0x12345678 in its ACCESS cycle.
REQ-034 ramREN addr 0x40 c0; addr changed to 0x44 at c2 -> BUSY c1-c4, ACCESS c5 with ramload=array[0x44].
REQ-035 ramREN and ramWEN both high c0-c3 -> ERROR c1-c4, array unchanged; both low c4 -> FREE c5. Out-of-range addr (DEPTH*4) with REN -> ERROR next cycle.
REQ-036 ramWEN addr 0x80 data 0xAAAA5555, RST high at c2 (BUSY) -> FREE c3; later read of 0x80 returns the prior value.
REQ-037 LAT=0, REN held on addresses 0x0 then 0x4 -> FREE c0, ACCESS c1 (word 0), ACCESS c2 (word 1).

Source files
------------

// File: rtl/ram_timing_ctrl.sv
// Word-addressed RAM model with a programmable access latency and a FREE/BUSY/ACCESS/ERROR handshake.
// A request must be held stable for LAT cycles; any change restarts the wait.

package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_timing_ctrl
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 16384
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int CW = $clog2(LAT + 1) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [29:0] idx;
        word_t       data;
    } req_t;

    state_t          state, nstate;
    logic [CW-1:0]   cnt, ncnt;
    req_t            lat, nlat;
    req_t            cur;
    logic            in_range, req_none, req_valid;
    logic            acc_rd, acc_wr;
    word_t           mem [DEPTH];

    // Byte-lane bits of the address carry no meaning for a word array.
    wire unused_addr_lsb = ^ramaddr[1:0];

    always_comb begin
        cur.ren  = ramREN;
        cur.wen  = ramWEN;
        cur.idx  = ramaddr[31:2];
        cur.data = ramstore;
    end

    assign in_range  = ({2'b00, ramaddr[31:2]} < 32'(DEPTH));
    assign req_none  = !ramREN && !ramWEN;
    assign req_valid = (ramREN ^ ramWEN) && in_range;

    always_comb begin
        nstate = state;
        ncnt   = '0;
        nlat   = lat;
        case (state)
            WAIT: begin
                if (req_none) begin
                    nstate = IDLE;
                end else if (!req_valid) begin
                    nstate = ERR;
                end else if (cur != lat) begin
                    nstate = WAIT;
                    nlat   = cur;
                    ncnt   = CW'(1);
                end else if (cnt == CW'(LAT)) begin
                    nstate = ACC;
                end else begin
                    nstate = WAIT;
                    ncnt   = CW'(cnt + 1'b1);
                end
            end
            // IDLE, ACC and ERR all treat the inputs as a fresh request.
            default: begin
                if (req_none) begin
                    nstate = IDLE;
                end else if (!req_valid) begin
                    nstate = ERR;
                end else begin
                    nlat = cur;
                    if (LAT == 0) begin
                        nstate = ACC;
                    end else begin
                        nstate = WAIT;
                        ncnt   = CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            lat   <= nlat;
        end
    end

    assign acc_rd = (state == ACC) && lat.ren;
    assign acc_wr = (state == ACC) && lat.wen;

    // Array is never reset; a reset coinciding with ACC-write drops the write.
    always_ff @(posedge CLK) begin
        if (!RST && acc_wr)
            mem[lat.idx[AW-1:0]] <= lat.data;
    end

    assign ramload = acc_rd ? mem[lat.idx[AW-1:0]] : '0;

    always_comb begin
        ramstate = FREE;
        case (state)
            IDLE:    ramstate = FREE;
            WAIT:    ramstate = BUSY;
            ACC:     ramstate = ACCESS;
            ERR:     ramstate = ERROR;
            default: ramstate = FREE;
        endcase
    end

endmodule

// File: tb/tb_ram_timing_ctrl.sv
// Scoreboard bench: a transaction-level model predicts ramstate/ramload each cycle; monitors compare on negedge.
// A second instance with LAT=0 and a tiny array covers the zero-latency path.

module tb_ram_timing_ctrl;
    import cpu_types_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 16384;

    logic      CLK = 1'b0;
    logic      RST, ren, wen;
    word_t     addr, store, load;
    ramstate_t state;

    logic      rst0, ren0, wen0;
    word_t     addr0, store0, load0;
    ramstate_t state0;

    always #5 CLK = ~CLK;

    ram_timing_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramload(load), .ramstate(state)
    );

    ram_timing_ctrl #(.LAT(0), .DEPTH(16)) dut0 (
        .CLK(CLK), .RST(rst0), .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0),
        .ramstore(store0), .ramload(load0), .ramstate(state0)
    );

    typedef struct {
        ramstate_t st;
        word_t     ld;
    } exp_t;

    exp_t  exp_q[$], exp0_q[$];
    string tag_q[$], tag0_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: what the block is showing now, plus the request being held.
    ramstate_t   m_st = FREE;
    logic        m_ren = 1'b0, m_wen = 1'b0;
    logic [29:0] m_idx = '0;
    word_t       m_data = '0;
    int          streak = 0;
    word_t       mmem [int];

    function automatic word_t mrd(input logic [29:0] i);
        return mmem.exists(int'(i)) ? mmem[int'(i)] : 32'h0;
    endfunction

    task automatic step(input logic r, input logic rn, input logic wn,
                        input word_t a, input word_t d, input string tag);
        exp_t        e;
        logic [29:0] idx;
        logic        none, ok;
        RST = r; ren = rn; wen = wn; addr = a; store = d;
        e.st = m_st;
        e.ld = (m_st == ACCESS && m_ren) ? mrd(m_idx) : 32'h0;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        if (m_st == ACCESS && m_wen && !r)
            mmem[int'(m_idx)] = m_data;
        idx  = a[31:2];
        none = !rn && !wn;
        ok   = (rn != wn) && (int'(idx) < DEPTH);
        if (r) begin
            m_st = FREE; streak = 0;
            m_ren = 1'b0; m_wen = 1'b0; m_idx = '0; m_data = '0;
        end else if (none) begin
            m_st = FREE;
        end else if (!ok) begin
            m_st = ERROR;
        end else if (m_st == BUSY && {rn, wn, idx, d} == {m_ren, m_wen, m_idx, m_data}) begin
            streak++;
            if (streak > LAT) m_st = ACCESS;
        end else begin
            m_ren = rn; m_wen = wn; m_idx = idx; m_data = d;
            streak = 1;
            m_st = (LAT == 0) ? ACCESS : BUSY;
        end
        @(posedge CLK); #1;
    endtask

    task automatic hold(input int n, input logic rn, input logic wn,
                        input word_t a, input word_t d, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, rn, wn, a, d, tag);
    endtask

    task automatic step0(input logic rn, input logic wn, input word_t a, input word_t d,
                         input ramstate_t est, input word_t eld, input string tag);
        exp_t e;
        rst0 = 1'b0; ren0 = rn; wen0 = wn; addr0 = a; store0 = d;
        e.st = est; e.ld = eld;
        exp0_q.push_back(e);
        tag0_q.push_back(tag);
        @(posedge CLK); #1;
    endtask

    always @(negedge CLK) begin
        exp_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (state !== e.st || load !== e.ld) begin
                errors++;
                $display("FAIL %s: got state=%s load=%08h, want state=%s load=%08h",
                         t, state.name(), load, e.st.name(), e.ld);
            end
        end
    end

    always @(negedge CLK) begin
        exp_t  e;
        string t;
        if (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            t = tag0_q.pop_front();
            checks++;
            if (state0 !== e.st || load0 !== e.ld) begin
                errors++;
                $display("FAIL %s: got state=%s load=%08h, want state=%s load=%08h",
                         t, state0.name(), load0, e.st.name(), e.ld);
            end
        end
    end

    function automatic word_t pick_addr(input logic oor);
        word_t a;
        if (oor) begin
            if ($urandom_range(0, 1) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 7)) * 4;
            else                           a = 32'hFFFF_FFF0;
        end else begin
            a = {22'h0, 8'($urandom_range(16, 23)), 2'b00};
        end
        return a;
    endfunction

    initial begin
        logic  cr, cw, r;
        word_t ca, cd;
        int    k;
        RST = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; store = '0;
        rst0 = 1'b1; ren0 = 1'b0; wen0 = 1'b0; addr0 = '0; store0 = '0;
        @(posedge CLK); #1;

        // Zero-latency instance: held requests hit ACCESS every cycle.
        step0(1'b0, 1'b1, 32'h0,  32'hA5A5_0001, FREE,   32'h0,         "lat0_reset");
        step0(1'b0, 1'b1, 32'h4,  32'hA5A5_0002, ACCESS, 32'h0,         "lat0_wr0");
        step0(1'b1, 1'b0, 32'h0,  32'h0,         ACCESS, 32'h0,         "lat0_wr1");
        step0(1'b1, 1'b0, 32'h4,  32'h0,         ACCESS, 32'hA5A5_0001, "lat0_rd0");
        step0(1'b0, 1'b0, 32'h0,  32'h0,         ACCESS, 32'hA5A5_0002, "lat0_rd1");
        step0(1'b1, 1'b0, 32'd64, 32'h0,         FREE,   32'h0,         "lat0_free");
        step0(1'b0, 1'b0, 32'h0,  32'h0,         ERROR,  32'h0,         "lat0_oor");
        step0(1'b0, 1'b0, 32'h0,  32'h0,         FREE,   32'h0,         "lat0_recover");

        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "reset");
        step(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, "reset_held");

        hold(3, 1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, "preload_100");
        hold(1, 1'b0, 1'b0, 32'h0,   32'h0,         "preload_done");
        hold(4, 1'b1, 1'b0, 32'h100, 32'h0,         "read_100");
        hold(2, 1'b0, 1'b0, 32'h0,   32'h0,         "read_100_drop");

        hold(3, 1'b0, 1'b1, 32'h40, 32'h1234_5678, "write_40");
        hold(1, 1'b0, 1'b0, 32'h0,  32'h0,         "write_40_drop");
        hold(3, 1'b1, 1'b0, 32'h40, 32'h0,         "readback_40");
        hold(1, 1'b0, 1'b0, 32'h0,  32'h0,         "readback_40_drop");

        hold(3, 1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, "write_44");
        hold(1, 1'b0, 1'b0, 32'h0,  32'h0,         "write_44_drop");
        hold(2, 1'b1, 1'b0, 32'h40, 32'h0,         "restart_40");
        hold(3, 1'b1, 1'b0, 32'h44, 32'h0,         "restart_44");
        hold(2, 1'b0, 1'b0, 32'h0,  32'h0,         "restart_drop");

        hold(4, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, "both_high");
        hold(2, 1'b0, 1'b0, 32'h0,  32'h0,         "both_drop");
        hold(1, 1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, "out_of_range");
        hold(2, 1'b0, 1'b0, 32'h0,  32'h0,         "oor_drop");
        hold(3, 1'b1, 1'b0, 32'h40, 32'h0,         "after_err_40");
        hold(1, 1'b0, 1'b0, 32'h0,  32'h0,         "after_err_drop");

        hold(2, 1'b0, 1'b1, 32'h80, 32'hAAAA_5555, "write_80");
        step(1'b1, 1'b0, 1'b1, 32'h80, 32'hAAAA_5555, "reset_in_busy");
        hold(1, 1'b0, 1'b0, 32'h0,  32'h0,         "after_busy_reset");
        hold(3, 1'b1, 1'b0, 32'h80, 32'h0,         "read_80");
        hold(1, 1'b0, 1'b0, 32'h0,  32'h0,         "read_80_drop");

        hold(3, 1'b0, 1'b1, 32'h84, 32'h0000_0055, "write_84");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0,       "reset_in_acc_write");
        hold(3, 1'b1, 1'b0, 32'h84, 32'h0,         "read_84");
        hold(1, 1'b0, 1'b0, 32'h0,  32'h0,         "read_84_drop");

        cr = 1'b0; cw = 1'b0; ca = '0; cd = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 25) begin
                k = int'($urandom_range(0, 99));
                if (k < 15)      begin cr = 1'b0; cw = 1'b0; end
                else if (k < 50) begin cr = 1'b1; cw = 1'b0; ca = pick_addr(1'b0); end
                else if (k < 85) begin cr = 1'b0; cw = 1'b1; ca = pick_addr(1'b0); cd = $urandom; end
                else if (k < 93) begin cr = 1'b1; cw = 1'b1; ca = pick_addr(1'b0); end
                else             begin cr = 1'b1; cw = 1'b0; ca = pick_addr(1'b1); end
            end
            r = ($urandom_range(0, 99) < 2) && !(m_st == ACCESS && m_ren);
            step(r, cr, cw, {ca[31:2], 2'($urandom_range(0, 3))}, cd, "random");
        end

        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "final_idle");
        repeat (2) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", exp_q.size(), exp0_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
